output_reader: RTL and testbench

OUTPUT_READER -- requirements
Module: output_reader

---
 rtl/output_reader.sv | 126 ++++++++++++
 tb/tb_output_reader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/output_reader.sv
// Drains words from the result store and streams each one out as
// OUT_WIDTH-wide slices, least-significant slice first, over a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start, count       begin a drain of count words (count sampled with start)
//   sram_re/raddr      read request to the result store
//   sram_rdata         store read data, valid the cycle after sram_re
//   out_data/valid     current slice toward downstream
//   out_ready          downstream accepts the slice this cycle
//   busy, done         activity flag, one-cycle completion pulse
module output_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  sram_re,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int SLICES = DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [ADDR_WIDTH:0] DEPTH_T =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(SLICES - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   target;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] buf_q;

  logic last_slice;
  logic more_words;
  logic xfer;

  assign last_slice = (idx == LAST_IDX);
  // Compare in ADDR_WIDTH+1 bits so a full store (target == DEPTH)
  // stops at DEPTH-1 instead of wrapping the address.
  assign more_words =
    (({1'b0, addr} + (ADDR_WIDTH+1)'(1)) < target);
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr   <= '0;
      target <= '0;
      idx    <= '0;
      buf_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr <= '0;
            idx  <= '0;
            if (count == '0) begin
              state <= S_FINISH;
            end else begin
              target <= (count > DEPTH_T) ? DEPTH_T : count;
              state  <= S_READ;
            end
          end
        end
        S_READ: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          buf_q <= sram_rdata;
          state <= S_SEND;
        end
        S_SEND: begin
          if (xfer) begin
            if (!last_slice) begin
              idx <= idx + IDX_W'(1);
            end else begin
              idx <= '0;
              if (more_words) begin
                addr  <= addr + ADDR_WIDTH'(1);
                state <= S_READ;
              end else begin
                state <= S_FINISH;
              end
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them at once.
  assign sram_re    = (state == S_READ);
  assign sram_raddr = addr;
  assign out_valid  = (state == S_SEND);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FINISH);
  assign out_data   = out_valid ?
    buf_q[idx*OUT_WIDTH +: OUT_WIDTH] : '0;

endmodule

// File: tb/tb_output_reader.sv
// Scoreboard bench for output_reader: a behavioural result store,
// expected addresses/slices queued at start, checked as they appear.
module tb_output_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  count = '0;
  logic        sram_re;
  logic [3:0]  sram_raddr;
  logic [15:0] sram_rdata = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  output_reader #(
    .DATA_WIDTH(16),
    .DEPTH(16),
    .ADDR_WIDTH(4),
    .OUT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .count(count),
    .sram_re(sram_re),
    .sram_raddr(sram_raddr),
    .sram_rdata(sram_rdata),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];

  always @(posedge clk) begin
    if (sram_re) sram_rdata <= mem[sram_raddr];
  end

  int n_vec = 0;
  int n_err = 0;
  int addr_q[$];
  int data_q[$];
  int done_cnt = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sram_re) begin
      check("raddr_q", 32'(addr_q.size() != 0), 1);
      if (addr_q.size() != 0)
        check("raddr", 32'(sram_raddr), addr_q.pop_front());
    end
    if (out_valid) begin
      if (prev_stall)
        check("hold", 32'(out_data), 32'(prev_data));
      if (out_ready) begin
        check("slice_q", 32'(data_q.size() != 0), 1);
        if (data_q.size() != 0)
          check("slice", 32'(out_data), data_q.pop_front());
      end
      prev_stall = !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
      check("idle_data", 32'(out_data), 0);
    end
    if (done) done_cnt++;
  end

  task automatic push_expect(int n);
    for (int w = 0; w < n; w++) begin
      addr_q.push_back(w);
      for (int s = 0; s < 2; s++)
        data_q.push_back(int'((mem[w] >> (8*s)) & 16'h00ff));
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_re"},    32'(sram_re), 0);
    check({tag, "_raddr"}, 32'(sram_raddr), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_data"},  32'(out_data), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
  endtask

  // Cycle 1 is the cycle right after the edge that samples start.
  task automatic drain(int cnt, int stall, bit restart);
    int n;
    int cyc;
    int done_cyc;
    int fv_cyc;
    int stall_left;
    int exp_cyc;
    n = (cnt > 16) ? 16 : cnt;
    cyc = 1;
    done_cyc = -1;
    fv_cyc = -1;
    stall_left = 0;
    push_expect(n);
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    count = cnt[4:0];
    @(posedge clk); #1;
    start = 1'b0;
    count = '0;
    while (done_cyc < 0 && cyc <= 300) begin
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end
      if (out_valid && fv_cyc < 0) begin
        fv_cyc = cyc;
        if (stall > 0) begin
          out_ready = 1'b0;
          stall_left = stall;
        end
      end
      if (restart) begin
        start = (cyc == 4);
        count = (cyc == 4) ? 5'd1 : 5'd0;
      end
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    exp_cyc = (n == 0) ? 1 : n*4 + 1 + stall;
    check("done_seen", 32'(done_cyc >= 0), 1);
    check("done_cyc", done_cyc, exp_cyc);
    check("first_valid", fv_cyc, (n == 0) ? -1 : 3);
    repeat (3) @(posedge clk);
    #1;
    check("done_cnt", done_cnt, 1);
    check("busy_end", 32'(busy), 0);
    check("sb_left", addr_q.size() + data_q.size(), 0);
  endtask

  initial begin
    bit found;
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    for (int i = 2; i < 16; i++)
      mem[i] = 16'($urandom_range(0, 65535));

    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;

    drain(2, 0, 1'b0);
    drain(2, 5, 1'b0);
    drain(0, 0, 1'b0);
    drain(31, 0, 1'b0);
    drain(2, 0, 1'b1);

    push_expect(2);
    done_cnt = 0;
    found = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    count = 5'd2;
    @(posedge clk); #1;
    start = 1'b0;
    count = '0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (out_valid && sram_raddr == 4'd1) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("reach_w2", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid");
    addr_q.delete();
    data_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_nodone", done_cnt, 0);
    drain(1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
